// File: rtl/hsi_tx_sched.sv
// HSI master command-line transmit scheduler: BTC/SR/TM/CCW arbitration, retry and guard gap.
// Optional WAIT timeout enabled by defining HSI_SCHED_TIMEOUT_EN.
module hsi_tx_sched #(
  parameter int unsigned BTC_PERIOD = 48000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       btc_en,
  input  logic       sr_req,
  input  logic       tm_req,
  input  logic       ccw_req,
  input  logic       tx_done,
  input  logic       tx_nack,
  output logic [3:0] gnt,
  output logic       tx_start,
  output logic [3:0] ack,
  output logic [3:0] fail,
  output logic       busy,
  output logic [2:0] retry_cnt,
  output logic       btc_miss
);
  localparam int unsigned BW = $clog2(BTC_PERIOD);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;
  typedef enum logic {RR_TM, RR_CCW} rr_t;

  state_t          state_q, state_d;
  rr_t             rr_q, rr_d;
  logic [3:0]      gnt_q, gnt_d, ack_q, ack_d, fail_q, fail_d, win;
  logic            tx_start_q, tx_start_d, busy_q, busy_d;
  logic            btc_miss_q, btc_miss_d, btc_pend_q, btc_pend_d;
  logic            reissue_q, reissue_d;
  logic [2:0]      retry_q, retry_d;
  logic [BW-1:0]   btc_cnt_q, btc_cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            btc_wrap, btc_done, req_any, done_ev, nack_ev;

`ifdef HSI_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
  logic          to_hit;

  // Counter is zero on WAIT entry because it is held clear in every other state.
  always_comb begin
    to_hit = (state_q == S_WAIT) && (to_q == TW'(TIMEOUT));
    to_d   = (state_q == S_WAIT) ? to_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end

  assign done_ev = tx_done | to_hit;
  assign nack_ev = tx_nack | ~tx_done;
`else
  assign done_ev = tx_done;
  assign nack_ev = tx_nack;
`endif

  always_comb begin
    btc_wrap  = btc_en && (btc_cnt_q == BW'(BTC_PERIOD - 1));
    btc_cnt_d = (!btc_en || btc_wrap) ? '0 : btc_cnt_q + 1'b1;
  end

  // Fixed priority BTC > SR; TM/CCW alternate, rr holds the last one served.
  always_comb begin
    req_any = btc_pend_q | sr_req | tm_req | ccw_req;
    win     = 4'b1000;
    if (btc_pend_q)                                  win = 4'b0001;
    else if (sr_req)                                 win = 4'b0010;
    else if (tm_req && (!ccw_req || rr_q == RR_CCW)) win = 4'b0100;
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    tx_start_d = 1'b0;
    ack_d      = '0;
    fail_d     = '0;
    retry_d    = retry_q;
    reissue_d  = reissue_q;
    gap_d      = gap_q;
    case (state_q)
      S_IDLE: begin
        if (en && req_any) begin
          state_d    = S_START;
          gnt_d      = win;
          tx_start_d = 1'b1;
          retry_d    = '0;
          if (win[2]) rr_d = RR_TM;
          if (win[3]) rr_d = RR_CCW;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (done_ev) begin
          state_d = S_GAP;
          gap_d   = '0;
          if (nack_ev && retry_q < 3'(MAX_RETRY)) begin
            retry_d   = retry_q + 1'b1;
            reissue_d = 1'b1;
          end else begin
            if (nack_ev) fail_d = gnt_q;
            else         ack_d  = gnt_q;
            gnt_d     = '0;
            reissue_d = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (reissue_q) begin
            state_d    = S_START;
            tx_start_d = 1'b1;
            reissue_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // A wrap coinciding with BTC completion re-arms the pending flag without a miss.
  always_comb begin
    btc_done   = ack_d[0] | fail_d[0];
    btc_pend_d = (btc_pend_q & ~btc_done) | btc_wrap;
    btc_miss_d = btc_wrap & btc_pend_q & ~btc_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= RR_TM;
      gnt_q      <= '0;
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      fail_q     <= '0;
      busy_q     <= 1'b0;
      retry_q    <= '0;
      reissue_q  <= 1'b0;
      gap_q      <= '0;
      btc_cnt_q  <= '0;
      btc_pend_q <= 1'b0;
      btc_miss_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      tx_start_q <= tx_start_d;
      ack_q      <= ack_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
      retry_q    <= retry_d;
      reissue_q  <= reissue_d;
      gap_q      <= gap_d;
      btc_cnt_q  <= btc_cnt_d;
      btc_pend_q <= btc_pend_d;
      btc_miss_q <= btc_miss_d;
    end
  end

  assign gnt       = gnt_q;
  assign tx_start  = tx_start_q;
  assign ack       = ack_q;
  assign fail      = fail_q;
  assign busy      = busy_q;
  assign retry_cnt = retry_q;
  assign btc_miss  = btc_miss_q;
endmodule

// File: tb/tb_hsi_tx_sched.sv
// Self-checking bench for hsi_tx_sched: directed vectors, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_hsi_tx_sched;
  localparam int unsigned P   = 100;
  localparam int unsigned MR  = 3;
  localparam int unsigned GAP = 16;

  logic clk = 1'b0;
  logic rst, en, btc_en, sr_req, tm_req, ccw_req, tx_done, tx_nack;
  logic [3:0] gnt, ack, fail;
  logic tx_start, busy, btc_miss;
  logic [2:0] retry_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic       sr;
    logic       tm;
    logic       ccw;
    logic [3:0] gnt;
  } vec_t;
  vec_t tbl [10];
  logic [3:0] alt [4];

  // reference-model state for the randomized run
  bit m_idle, m_nack, last_ccw, r_sr, r_tm, r_ccw;
  int start_c, done_c, eval_c, exp_start, idle_from, tries;
  int miss_n, miss_at, n_start, n_ack;
  logic [3:0] m_gnt, e_ack, e_fail;

  always #5 clk = ~clk;

  hsi_tx_sched #(.BTC_PERIOD(P), .MAX_RETRY(MR), .GAP_CYCLES(GAP), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .en(en), .btc_en(btc_en),
    .sr_req(sr_req), .tm_req(tm_req), .ccw_req(ccw_req),
    .tx_done(tx_done), .tx_nack(tx_nack),
    .gnt(gnt), .tx_start(tx_start), .ack(ack), .fail(fail),
    .busy(busy), .retry_cnt(retry_cnt), .btc_miss(btc_miss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, busy, 0);
  endtask

  // Called while observing START; returns observing the cycle after tx_done.
  task automatic finish_frame(input bit nack, input int dly);
    tick();
    chk("wait_entry_txs", tx_start, 0);
    repeat (dly) tick();
    tx_done = 1'b1;
    tx_nack = nack;
    tick();
    tx_done = 1'b0;
    tx_nack = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 4'b0010};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 4'b1000};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 4'b0100};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 4'b0100};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 4'b1000};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 4'b1000};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 4'b0100};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 4'b0010};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 4'b1000};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 4'b0100};
    alt[0] = 4'b1000; alt[1] = 4'b0100; alt[2] = 4'b1000; alt[3] = 4'b0100;

    rst = 1'b1; en = 1'b0; btc_en = 1'b0; sr_req = 1'b0; tm_req = 1'b0;
    ccw_req = 1'b0; tx_done = 1'b0; tx_nack = 1'b0;
    tick();
    chk("rst_gnt", gnt, 0); chk("rst_txs", tx_start, 0); chk("rst_ack", ack, 0);
    chk("rst_fail", fail, 0); chk("rst_busy", busy, 0); chk("rst_retry", retry_cnt, 0);
    chk("rst_miss", btc_miss, 0);
    tick();
    rst = 1'b0;
    tick();

    // single TM frame with exact latencies
    en = 1'b1; tm_req = 1'b1;
    tick();
    chk("t1_gnt", gnt, 4'b0100); chk("t1_txs", tx_start, 1);
    chk("t1_busy", busy, 1); chk("t1_retry", retry_cnt, 0);
    finish_frame(0, 5);
    chk("t1_ack", ack, 4'b0100); chk("t1_gnt_clr", gnt, 0); chk("t1_busy_gap", busy, 1);
    tm_req = 1'b0;
    repeat (GAP - 1) tick();
    chk("t1_busy_end_gap", busy, 1);
    tick();
    chk("t1_busy_fall", busy, 0);

    // tx_done while idle has no effect
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_done_ack", ack, 0); chk("idle_done_busy", busy, 0);

    for (int i = 0; i < 10; i++) begin
      sr_req = tbl[i].sr; tm_req = tbl[i].tm; ccw_req = tbl[i].ccw;
      tick();
      chk("tbl_txs", tx_start, 1);
      chk("tbl_gnt", gnt, tbl[i].gnt);
      finish_frame(0, i % 4);
      chk("tbl_ack", ack, tbl[i].gnt);
      sr_req = 1'b0; tm_req = 1'b0; ccw_req = 1'b0;
      wait_idle("tbl_idle");
    end

    // TM and CCW held together: alternation and minimum inter-frame spacing
    tm_req = 1'b1; ccw_req = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("alt_txs", tx_start, 1);
      chk("alt_gnt", gnt, alt[i]);
      finish_frame(0, 2);
      chk("alt_ack", ack, alt[i]);
      if (i < 3) begin
        repeat (GAP) tick();
        chk("alt_no_early_start", tx_start, 0);
        tick();
      end
    end
    tm_req = 1'b0; ccw_req = 1'b0;
    wait_idle("alt_idle");

    // CCW nacked every attempt; en and request drop mid-frame do not abort it
    ccw_req = 1'b1;
    tick();
    for (int a = 0; a <= int'(MR); a++) begin
      chk("rty_txs", tx_start, 1);
      chk("rty_cnt", retry_cnt, a);
      chk("rty_gnt", gnt, 4'b1000);
      if (a == 0) en = 1'b0;
      if (a == 1) ccw_req = 1'b0;
      finish_frame(1, 3);
      if (a < int'(MR)) begin
        chk("rty_inc", retry_cnt, a + 1);
        chk("rty_hold", gnt, 4'b1000);
        chk("rty_noack", ack, 0);
        chk("rty_nofail", fail, 0);
        repeat (GAP) tick();
      end else begin
        chk("rty_fail", fail, 4'b1000);
        chk("rty_final_noack", ack, 0);
        chk("rty_gnt_clr", gnt, 0);
      end
    end
    n_ack = 0;
    repeat (GAP + 5) begin
      tick();
      if (ack !== 4'b0000) n_ack++;
    end
    chk("rty_ack_never", n_ack, 0);
    en = 1'b1;

    // BTC period timer with arbitration blocked
    en = 1'b0; btc_en = 1'b1;
    miss_n = 0; miss_at = 0;
    for (int k = 1; k <= 250; k++) begin
      tick();
      if (btc_miss === 1'b1) begin
        miss_n++;
        miss_at = k;
      end
    end
    chk("btc_miss_count", miss_n, 1);
    chk("btc_miss_cycle", miss_at, 200);
    btc_en = 1'b0; sr_req = 1'b1; tm_req = 1'b1; en = 1'b1;
    tick();
    chk("order_btc", gnt, 4'b0001); chk("order_btc_txs", tx_start, 1);
    finish_frame(0, 1);
    chk("order_btc_ack", ack, 4'b0001);
    repeat (GAP + 1) tick();
    chk("order_sr", gnt, 4'b0010); chk("order_sr_txs", tx_start, 1);
    finish_frame(0, 1);
    chk("order_sr_ack", ack, 4'b0010);
    sr_req = 1'b0;
    repeat (GAP + 1) tick();
    chk("order_tm", gnt, 4'b0100); chk("order_tm_txs", tx_start, 1);
    finish_frame(0, 1);
    chk("order_tm_ack", ack, 4'b0100);
    tm_req = 1'b0;
    n_start = 0;
    repeat (60) begin
      tick();
      if (tx_start === 1'b1) n_start++;
    end
    chk("btc_once", n_start, 0);

    // asynchronous reset during WAIT of a retried SR frame
    sr_req = 1'b1;
    tick();
    chk("rst_mid_gnt", gnt, 4'b0010);
    finish_frame(1, 2);
    repeat (GAP) tick();
    chk("rst_mid_retry_start", tx_start, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rstw_gnt", gnt, 0); chk("rstw_busy", busy, 0); chk("rstw_retry", retry_cnt, 0);
    chk("rstw_txs", tx_start, 0); chk("rstw_ack", ack, 0); chk("rstw_fail", fail, 0);
    chk("rstw_miss", btc_miss, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstw_regnt", gnt, 4'b0010); chk("rstw_regnt_retry", retry_cnt, 0);
    chk("rstw_regnt_txs", tx_start, 1);
    finish_frame(0, 1);
    chk("rstw_ack_after", ack, 4'b0010);
    sr_req = 1'b0;
    wait_idle("rstw_idle");

    tm_req = 1'b1;
    tick();
    chk("hold_txs", tx_start, 1);
`ifdef HSI_SCHED_TIMEOUT_EN
    tick();
    n_start = 0;
    while (tx_start !== 1'b1 && n_start < 200) begin
      tick();
      n_start++;
    end
    chk("timeout_restart", n_start, 50 + GAP + 1);
    chk("timeout_retry", retry_cnt, 1);
`else
    repeat (10000) tick();
    chk("hold_gnt", gnt, 4'b0100); chk("hold_busy", busy, 1);
`endif
    finish_frame(0, 1);
    chk("hold_ack", ack, 4'b0100);
    tm_req = 1'b0;
    wait_idle("hold_idle");

    // randomized run against the transaction-level model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_idle = 1'b1; last_ccw = 1'b0; r_sr = 1'b0; r_tm = 1'b0; r_ccw = 1'b0;
    start_c = -100; done_c = -100; eval_c = -1; exp_start = -1; idle_from = -1;
    tries = 0; m_gnt = '0; m_nack = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      e_ack = '0;
      e_fail = '0;
      if (c == idle_from) m_idle = 1'b1;
      if (c == eval_c) begin
        if (m_nack && tries < int'(MR)) begin
          tries++;
          exp_start = done_c + int'(GAP) + 1;
          chk("rnd_retry_cnt", retry_cnt, tries);
          chk("rnd_retry_gnt", gnt, m_gnt);
        end else begin
          if (m_nack) e_fail = m_gnt;
          else        e_ack  = m_gnt;
          if (m_gnt[1]) r_sr = 1'b0;
          if (m_gnt[2]) r_tm = 1'b0;
          if (m_gnt[3]) r_ccw = 1'b0;
          idle_from = done_c + int'(GAP) + 1;
          chk("rnd_gnt_clr", gnt, 0);
        end
      end
      chk("rnd_txs", tx_start, (c == exp_start));
      chk("rnd_ack", ack, e_ack);
      chk("rnd_fail", fail, e_fail);
      chk("rnd_busy", busy, !m_idle);
      if (c == exp_start) begin
        chk("rnd_gnt", gnt, m_gnt);
        chk("rnd_start_cnt", retry_cnt, tries);
        start_c = c;
        done_c  = c + int'($urandom_range(1, 6));
        eval_c  = done_c + 1;
        m_nack  = ($urandom_range(0, 2) == 0);
      end
      if (!r_sr  && $urandom_range(0, 9) == 0) r_sr  = 1'b1;
      if (!r_tm  && $urandom_range(0, 9) == 0) r_tm  = 1'b1;
      if (!r_ccw && $urandom_range(0, 9) == 0) r_ccw = 1'b1;
      en = ($urandom_range(0, 7) != 0);
      if (c == done_c) begin
        tx_done = 1'b1;
        tx_nack = m_nack;
      end else if (!(start_c < c && c <= done_c) && $urandom_range(0, 15) == 0) begin
        tx_done = 1'b1;
        tx_nack = 1'($urandom_range(0, 1));
      end else begin
        tx_done = 1'b0;
        tx_nack = 1'b0;
      end
      if (m_idle && en && (r_sr || r_tm || r_ccw)) begin
        if (r_sr)                                m_gnt = 4'b0010;
        else if (r_tm && r_ccw)                  m_gnt = last_ccw ? 4'b0100 : 4'b1000;
        else if (r_tm)                           m_gnt = 4'b0100;
        else                                     m_gnt = 4'b1000;
        if (m_gnt[2]) last_ccw = 1'b0;
        if (m_gnt[3]) last_ccw = 1'b1;
        tries = 0;
        exp_start = c + 1;
        m_idle = 1'b0;
      end
      sr_req = r_sr; tm_req = r_tm; ccw_req = r_ccw;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hsi_tx_sched.md
# hsi_tx_sched

Transmit scheduler for the HSI master command line. It arbitrates four frame sources onto the single COM transmitter:

- the periodic board time code (BTC),
- the service-data request (SR),
- the telemetry request (TM),
- the command word (CCW).

It issues one frame at a time, retries frames the slave rejects, and enforces an inter-frame guard gap. It sits between the TM/SR generator and CCW generator on one side and hsi_master on the other, in the 48 MHz domain.

## Interface
- BTC_PERIOD, 48000, BTC interval in clk cycles (1 ms at 48 MHz); legal range is ≥ 2.
- MAX_RETRY, 3, retries after the first attempt; range 0..7.
- GAP_CYCLES, 16, idle cycles between frames; range ≥ 1.
- TIMEOUT, 4096, clk cycles to wait for tx_done. Used only with HSI_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, CLK_48.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scheduler enable.
- btc_en  in  1  enables the BTC period timer.
- sr_req / tm_req / ccw_req  in  1 each  request levels, held until ack or fail.
- tx_done  in  1  one-cycle pulse from the master: frame finished.
- tx_nack  in  1  qualifies tx_done: the slave requested a repeat.
- gnt  out  4  one-hot grant: [0] BTC, [1] SR, [2] TM, [3] CCW.
- tx_start  out  1  one-cycle pulse that launches a frame for gnt.
- ack  out  4  one-cycle pulse per source on successful completion.
- fail  out  4  one-cycle pulse per source when retries are exhausted.
- busy  out  1  high whenever state ≠ IDLE.
- retry_cnt  out  3  attempt index of the current frame.
- btc_miss  out  1  one-cycle pulse when a BTC period expires while the previous BTC is still pending.

## Operation
- **Reset values:** state = IDLE, rr = TM.
  - gnt, tx_start, ack, fail, busy, retry_cnt and btc_miss are all 0.
  - The BTC timer is 0 and btc_pend is 0.
- **BTC timer:**
  - While btc_en = 1, it counts 0..BTC_PERIOD-1 and wraps.
  - On wrap it sets btc_pend. If btc_pend is already set, it also pulses btc_miss; the pending flag stays set and is not duplicated.
  - While btc_en = 0, the timer is held at 0. btc_pend is unaffected.
  - btc_pend clears when the BTC frame completes (ack[0] or fail[0]).
- **FSM states:** IDLE, START, WAIT, GAP.
- **IDLE:** if en = 1 and any request is pending, latch the winner and move to START; otherwise stay in IDLE.
  - Priority: btc_pend first, then sr_req.
  - TM and CCW are round-robin: on contention, the source other than the last-served one wins. rr updates on each TM or CCW grant.
- **START:** pulse tx_start, set retry_cnt = 0 on a fresh arbitration, then go to WAIT.
- **WAIT:** on tx_done, go to GAP.
  - tx_nack = 0: pulse ack for the granted source and clear gnt.
  - tx_nack = 1 and retry_cnt < MAX_RETRY: increment retry_cnt, keep gnt, and mark the frame for re-issue.
  - tx_nack = 1 and retry_cnt = MAX_RETRY: pulse fail and clear gnt.
- **GAP:** count GAP_CYCLES.
  - With a re-issue marked, go to START with the same gnt and no arbitration.
  - Otherwise go to IDLE.
- tx_done outside WAIT is ignored.
- A request dropped while granted does not abort the frame.
- en = 0 only blocks new arbitration in IDLE. A frame or retry already in progress completes.
- rst mid-frame returns every output to its reset value immediately. The pending requester must keep requesting to be served.

## Timing
- Request at cycle n in IDLE: gnt and busy are valid and tx_start pulses at n+1. WAIT begins at n+2.
- gnt stays stable from START until the cycle after tx_done (success or fail), or through GAP on a retry.
- tx_done at cycle m: ack, fail or the retry_cnt increment appear at m+1, registered. GAP occupies m+1..m+GAP_CYCLES.
- Re-issue: tx_start at m+GAP_CYCLES+1.
- Next arbitration takes place in IDLE at m+GAP_CYCLES+1, so a new tx_start comes no earlier than m+GAP_CYCLES+2.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Configuration
- **HSI_SCHED_TIMEOUT_EN defined:** a counter runs in WAIT.
  - Reaching TIMEOUT cycles without tx_done is treated exactly as tx_done with tx_nack = 1 (retry or fail).
  - The counter clears on entry to WAIT.
- **Not defined:** WAIT holds indefinitely until tx_done. The TIMEOUT parameter is unused.

## Test plan
- After reset, assert tm_req = 1 at cycle 10 → gnt = 4'b0100 and tx_start at 11. tx_done (nack = 0) at 30 → ack[2] at 31, busy falls at 31+GAP_CYCLES.
- Hold sr_req and tm_req together with btc_pend set → serve order is BTC, then SR, then TM. With tm_req and ccw_req both held, grants alternate TM, CCW, TM, CCW.
- Answer every tx_done on a CCW frame with tx_nack = 1 and MAX_RETRY = 3 → 4 tx_start pulses with retry_cnt 0..3, gnt held, then fail[3] = 1 and ack[3] never pulses.
- BTC_PERIOD = 100 with btc_en = 1 and the scheduler blocked (en = 0) for 250 cycles → btc_pend set at 100 and btc_miss pulse at 200. Raising en then yields exactly one BTC frame.
- Assert rst during WAIT → all outputs are 0 in the same cycle. After release, a held sr_req is re-granted with retry_cnt = 0.
- With HSI_SCHED_TIMEOUT_EN, TIMEOUT = 50 and no tx_done → retry tx_start 50+GAP_CYCLES+1 cycles after WAIT entry. Without the macro, gnt is still held after 10000 cycles.
